// File: rtl/dram_arbiter.sv
// dram_arbiter: shares one single-port DRAM among NUM_CORES requesters (optional DRAM_ARBITER_FIXED_PRIO_EN).
// Latency: strobe one cycle after the request is sampled, ack the cycle after that; one access per 3 cycles.
// Backpressure: requests are level-held until acked; unserved ones wait, withdrawn ones are dropped silently.
module dram_arbiter #(
  parameter int NUM_CORES = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [16*NUM_CORES-1:0] i_req_addr,
  input  logic [2*NUM_CORES-1:0]  i_req_read,
  input  logic [2*NUM_CORES-1:0]  i_req_write,
  input  logic [8*NUM_CORES-1:0]  i_req_wdata,
  output logic [NUM_CORES-1:0]    o_ack,
  output logic [7:0]              o_rdata,
  output logic [15:0]             o_mem_addr,
  output logic [1:0]              o_mem_sel,
  output logic                    o_mem_re,
  output logic                    o_mem_we,
  output logic [7:0]              o_mem_wdata,
  input  logic [7:0]              i_mem_rdata,
  output logic                    o_busy,
  output logic                    o_err
);
  localparam int IW  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int IW1 = IW + 1;
  localparam logic [NUM_CORES-1:0] ONE_HOT0 = NUM_CORES'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t               state;
  logic [IW-1:0]        win_q;
  logic                 is_wr_q;
  logic [NUM_CORES-1:0] req;
  logic [IW-1:0]        win;
  logic                 found;
  logic [1:0]           win_rcode;
  logic [1:0]           win_wcode;
  logic                 win_wr;

  // A core is requesting when either of its codes is nonzero
  for (genvar k = 0; k < NUM_CORES; k++) begin : g_req
    assign req[k] = (|i_req_read[2*k +: 2]) | (|i_req_write[2*k +: 2]);
  end

`ifdef DRAM_ARBITER_FIXED_PRIO_EN
  // Fixed priority: the lowest requesting index wins
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (req[i]) begin
        win   = IW'(i);
        found = 1'b1;
      end
    end
  end
`else
  logic [IW-1:0] ptr;
  logic [IW:0]   idx;

  // Round-robin: first requester found scanning upward from ptr, wrapping at NUM_CORES
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = {1'b0, ptr} + IW1'(i);
      if (idx >= IW1'(NUM_CORES)) idx = idx - IW1'(NUM_CORES);
      if (!found && req[idx[IW-1:0]]) begin
        win   = idx[IW-1:0];
        found = 1'b1;
      end
    end
  end
`endif

  assign win_rcode = i_req_read[2*win +: 2];
  assign win_wcode = i_req_write[2*win +: 2];
  // Both codes set is a protocol error and resolves to a write
  assign win_wr    = (win_wcode != 2'b00);

  assign o_busy  = (state != IDLE);
  // DRAM read data arrives registered, i.e. exactly in the RESP cycle
  assign o_rdata = (state == RESP && !is_wr_q) ? i_mem_rdata : 8'h00;

  // Access FSM: latch the winner in IDLE, strobe during ISSUE, ack during RESP
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      win_q       <= '0;
      is_wr_q     <= 1'b0;
      o_ack       <= '0;
      o_mem_re    <= 1'b0;
      o_mem_we    <= 1'b0;
      o_err       <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_sel   <= '0;
      o_mem_wdata <= '0;
`ifndef DRAM_ARBITER_FIXED_PRIO_EN
      ptr         <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state       <= ISSUE;
            win_q       <= win;
            is_wr_q     <= win_wr;
            o_mem_addr  <= i_req_addr[16*win +: 16];
            o_mem_sel   <= win_wr ? win_wcode : win_rcode;
            o_mem_wdata <= i_req_wdata[8*win +: 8];
            o_mem_re    <= !win_wr;
            o_mem_we    <= win_wr;
            if (win_rcode != 2'b00 && win_wcode != 2'b00) o_err <= 1'b1;
`ifndef DRAM_ARBITER_FIXED_PRIO_EN
            ptr         <= (win == IW'(NUM_CORES - 1)) ? '0 : win + IW'(1);
`endif
          end
        end
        ISSUE: begin
          state    <= RESP;
          o_mem_re <= 1'b0;
          o_mem_we <= 1'b0;
          o_ack    <= ONE_HOT0 << win_q;
        end
        RESP: begin
          state <= IDLE;
          o_ack <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dram_arbiter.sv
`timescale 1ns/1ps
module tb_dram_arbiter;
  localparam int N = 4;

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic [16*N-1:0] i_req_addr;
  logic [2*N-1:0]  i_req_read;
  logic [2*N-1:0]  i_req_write;
  logic [8*N-1:0]  i_req_wdata;
  logic [N-1:0]    o_ack;
  logic [7:0]      o_rdata;
  logic [15:0]     o_mem_addr;
  logic [1:0]      o_mem_sel;
  logic            o_mem_re;
  logic            o_mem_we;
  logic [7:0]      o_mem_wdata;
  logic [7:0]      i_mem_rdata = 8'h00;
  logic            o_busy;
  logic            o_err;

  dram_arbiter #(.NUM_CORES(N)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req_addr(i_req_addr), .i_req_read(i_req_read),
    .i_req_write(i_req_write), .i_req_wdata(i_req_wdata), .o_ack(o_ack), .o_rdata(o_rdata),
    .o_mem_addr(o_mem_addr), .o_mem_sel(o_mem_sel), .o_mem_re(o_mem_re), .o_mem_we(o_mem_we),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .o_busy(o_busy), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] init_byte(input int key);
    return key[7:0] ^ key[17:10] ^ 8'h5A;
  endfunction

  // ---------------- DRAM device model (registered read) ----------------
  logic [7:0] dram_mem[int];
  always @(posedge i_clk) begin
    int key;
    key = int'({o_mem_sel, o_mem_addr});
    if (o_mem_we) dram_mem[key] = o_mem_wdata;
    if (o_mem_re) i_mem_rdata <= dram_mem.exists(key) ? dram_mem[key] : init_byte(key);
  end

  // ---------------- reference model ----------------
  typedef struct { int cyc; logic [15:0] addr; logic [1:0] sel; logic we; logic [7:0] wdata; } stb_t;
  typedef struct { int cyc; logic [N-1:0] ack; logic [7:0] rdata; } ack_t;
  stb_t stb_q[$];
  ack_t ack_q[$];
  logic [7:0] ref_mem[int];
  int   edge_n = 0, next_sample = 0, rr_ptr = 0, last_grant = -10;
  logic exp_err = 1'b0, exp_busy = 1'b0;
  logic [15:0] exp_addr = '0;
  logic [1:0]  exp_sel = '0;
  logic [7:0]  exp_wdata = '0;

  always @(posedge i_clk) begin : model
    int w, k, key;
    logic [1:0] rc, wc;
    stb_t s;
    ack_t a;
    edge_n++;
    if (i_rst) begin
      stb_q.delete(); ack_q.delete();
      rr_ptr = 0; next_sample = edge_n + 1; last_grant = -10;
      exp_err = 1'b0; exp_busy = 1'b0; exp_addr = '0; exp_sel = '0; exp_wdata = '0;
    end else begin
      w = -1;
      if (edge_n >= next_sample) begin
        for (int i = 0; i < N; i++) begin
`ifdef DRAM_ARBITER_FIXED_PRIO_EN
          k = i;
`else
          k = (rr_ptr + i) % N;
`endif
          if (w < 0 && (i_req_read[2*k +: 2] != 2'b00 || i_req_write[2*k +: 2] != 2'b00)) w = k;
        end
      end
      if (w >= 0) begin
        rc = i_req_read[2*w +: 2];
        wc = i_req_write[2*w +: 2];
        s.cyc = edge_n; s.addr = i_req_addr[16*w +: 16]; s.we = (wc != 2'b00);
        s.sel = s.we ? wc : rc; s.wdata = i_req_wdata[8*w +: 8];
        key = int'({s.sel, s.addr});
        a.cyc = edge_n + 1; a.ack = '0; a.ack[w] = 1'b1;
        if (s.we) begin
          ref_mem[key] = s.wdata;
          a.rdata = 8'h00;
        end else begin
          a.rdata = ref_mem.exists(key) ? ref_mem[key] : init_byte(key);
        end
        if (rc != 2'b00 && wc != 2'b00) exp_err = 1'b1;
        stb_q.push_back(s); ack_q.push_back(a);
        exp_addr = s.addr; exp_sel = s.sel; exp_wdata = s.wdata;
        next_sample = edge_n + 3; last_grant = edge_n; rr_ptr = (w + 1) % N;
      end
      exp_busy = (edge_n - last_grant) <= 1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int ack_log[$];
  int ack_cyc[$];
  always @(negedge i_clk) begin : monitor
    stb_t s;
    ack_t a;
    if (stb_q.size() > 0 && stb_q[0].cyc < edge_n) begin
      n_cmp++; n_bad++;
      $display("FAIL strobe_missing: no strobe occurred, expected one at cycle %0d", stb_q[0].cyc);
      void'(stb_q.pop_front());
    end
    if (ack_q.size() > 0 && ack_q[0].cyc < edge_n) begin
      n_cmp++; n_bad++;
      $display("FAIL ack_missing: no ack occurred, expected 0x%0h at cycle %0d", ack_q[0].ack, ack_q[0].cyc);
      void'(ack_q.pop_front());
    end
    if (o_mem_re || o_mem_we) begin
      if (stb_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL strobe_unexpected: re=%0b we=%0b at cycle %0d, expected none", o_mem_re, o_mem_we, edge_n);
      end else begin
        s = stb_q.pop_front();
        chk("stb_cycle", edge_n, s.cyc);
        chk("stb_re", o_mem_re, !s.we);
        chk("stb_we", o_mem_we, s.we);
        chk("stb_addr", o_mem_addr, s.addr);
        chk("stb_sel", o_mem_sel, s.sel);
        if (s.we) chk("stb_wdata", o_mem_wdata, s.wdata);
      end
    end
    if (o_ack !== '0) begin
      if (ack_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL ack_unexpected: ack=0x%0h at cycle %0d, expected none", o_ack, edge_n);
      end else begin
        a = ack_q.pop_front();
        chk("ack_cycle", edge_n, a.cyc);
        chk("ack_vec", o_ack, a.ack);
        chk("ack_rdata", o_rdata, a.rdata);
        for (int i = 0; i < N; i++) if (o_ack[i]) begin ack_log.push_back(i); ack_cyc.push_back(edge_n); end
      end
    end
    chk("busy", o_busy, exp_busy);
    chk("err", o_err, exp_err);
    chk("hold_addr", o_mem_addr, exp_addr);
    chk("hold_sel", o_mem_sel, exp_sel);
    chk("hold_wdata", o_mem_wdata, exp_wdata);
  end

  // ---------------- stimulus ----------------
  task automatic clear_reqs();
    i_req_addr = '0; i_req_read = '0; i_req_write = '0; i_req_wdata = '0;
  endtask

  task automatic set_req(input int k, input logic [15:0] addr, input logic [1:0] rd,
                         input logic [1:0] wr, input logic [7:0] wd);
    i_req_addr[16*k +: 16] = addr;
    i_req_read[2*k +: 2]   = rd;
    i_req_write[2*k +: 2]  = wr;
    i_req_wdata[8*k +: 8]  = wd;
  endtask

  task automatic pulse_reset();
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  initial begin
    int n_before;
    int exp_order[5];
    i_rst = 1'b1;
    clear_reqs();
    repeat (3) @(negedge i_clk);
    chk("rst_ack", o_ack, 4'b0000);
    chk("rst_rdata", o_rdata, 8'h00);
    chk("rst_addr", o_mem_addr, 16'h0000);
    chk("rst_sel", o_mem_sel, 2'b00);
    chk("rst_wdata", o_mem_wdata, 8'h00);
    chk("rst_re", o_mem_re, 1'b0);
    chk("rst_we", o_mem_we, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_err", o_err, 1'b0);
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);

    // core 2 reads 0x0105 region 01, DRAM holds 0x3C
    dram_mem[int'({2'b01, 16'h0105})] = 8'h3C;
    ref_mem[int'({2'b01, 16'h0105})]  = 8'h3C;
    set_req(2, 16'h0105, 2'b01, 2'b00, 8'h00);
    @(negedge i_clk);
    clear_reqs();
    chk("rd_re", o_mem_re, 1'b1);
    chk("rd_addr", o_mem_addr, 16'h0105);
    chk("rd_sel", o_mem_sel, 2'b01);
    @(negedge i_clk);
    chk("rd_ack", o_ack, 4'b0100);
    chk("rd_rdata", o_rdata, 8'h3C);
    repeat (3) @(negedge i_clk);

    // core 0 writes 0xA5 to 0x2000 region 10
    set_req(0, 16'h2000, 2'b00, 2'b10, 8'hA5);
    @(negedge i_clk);
    clear_reqs();
    chk("wr_we", o_mem_we, 1'b1);
    chk("wr_re", o_mem_re, 1'b0);
    chk("wr_wdata", o_mem_wdata, 8'hA5);
    @(negedge i_clk);
    chk("wr_we_once", o_mem_we, 1'b0);
    chk("wr_ack", o_ack, 4'b0001);
    repeat (3) @(negedge i_clk);

    // all cores request continuously from reset
    pulse_reset();
    ack_log.delete(); ack_cyc.delete();
    for (int k = 0; k < N; k++) set_req(k, 16'h0400 + 16'(k), 2'b11, 2'b00, 8'(k));
    repeat (15) @(negedge i_clk);
    clear_reqs();
`ifdef DRAM_ARBITER_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    chk("order_count_ge5", (ack_log.size() >= 5) ? 1 : 0, 1);
    for (int i = 0; i < 5; i++) begin
      if (i < ack_log.size()) chk($sformatf("order_%0d", i), ack_log[i], exp_order[i]);
      if (i > 0 && i < ack_cyc.size()) chk($sformatf("spacing_%0d", i), ack_cyc[i] - ack_cyc[i-1], 3);
    end
    repeat (4) @(negedge i_clk);

    // core 1 sets read and write together
    set_req(1, 16'h0330, 2'b01, 2'b11, 8'h77);
    @(negedge i_clk);
    clear_reqs();
    chk("both_we", o_mem_we, 1'b1);
    chk("both_sel", o_mem_sel, 2'b11);
    repeat (6) @(negedge i_clk);
    chk("both_err_sticky", o_err, 1'b1);

    // reset during the ISSUE cycle abandons the access
    set_req(3, 16'h0777, 2'b10, 2'b00, 8'h00);
    @(negedge i_clk);
    chk("abort_re", o_mem_re, 1'b1);
    n_before = ack_log.size();
    i_rst = 1'b1;
    clear_reqs();
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("abort_busy", o_busy, 1'b0);
    chk("abort_ack", o_ack, 4'b0000);
    chk("abort_err_clr", o_err, 1'b0);
    repeat (6) @(negedge i_clk);
    chk("abort_no_ack", ack_log.size(), n_before);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          int r;
          logic [1:0] code;
          r = $urandom_range(0, 9);
          code = 2'($urandom_range(1, 3));
          if (r < 4)      set_req(k, 16'h0, 2'b00, 2'b00, 8'h00);
          else if (r < 7) set_req(k, {12'h120, 4'($urandom_range(0, 15))}, code, 2'b00, 8'h00);
          else            set_req(k, {12'h120, 4'($urandom_range(0, 15))}, 2'b00, code, 8'($urandom));
        end
      end
      @(negedge i_clk);
    end
    clear_reqs();
    repeat (8) @(negedge i_clk);
    chk("drain_stb_q", stb_q.size(), 0);
    chk("drain_ack_q", ack_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameter NUM_CORES, default 4, meaning number of requesting cores (2..16).
REQ-002 i_clk  input  1  rising-edge clock for all state.
REQ-003 i_rst  input  1  synchronous, active-high reset.
REQ-004 i_req_addr  input  16*NUM_CORES  per-core DRAM address; core k occupies slice [16k+15:16k].
REQ-005 i_req_read  input  2*NUM_CORES  per-core read code: 00 = none, 01/10/11 = read of DRAM region 1/2/3.
REQ-006 i_req_write  input  2*NUM_CORES  per-core write code, same encoding as read.
REQ-007 i_req_wdata  input  8*NUM_CORES  per-core write byte.
REQ-008 o_ack  output  NUM_CORES  one-cycle completion pulse to the served core.
REQ-009 o_rdata  output  8  read byte; shared by all cores and valid while o_ack is high.
REQ-010 o_mem_addr  output  16  address to the single-port DRAM.
REQ-011 o_mem_sel  output  2  region code forwarded from the winning request.
REQ-012 o_mem_re / o_mem_we  output  1 each  DRAM read and write strobes.
REQ-013 o_mem_wdata  output  8  write byte to the DRAM.
REQ-014 i_mem_rdata  input  8  DRAM read data, registered, valid one cycle after o_mem_re.
REQ-015 o_busy  output  1  high in any state other than IDLE.
REQ-016 o_err  output  1  sticky protocol-error flag.

Function
REQ-017 A core is requesting when its read code or its write code is nonzero.
REQ-018 The FSM SHALL have three states (IDLE, ISSUE, RESP), and each SHALL last exactly one cycle except IDLE.
REQ-019 IDLE: with at least one request present, the block SHALL select a winner, latch its address, code, direction and wdata, and move to ISSUE; with no request it SHALL stay in IDLE.
REQ-020 ISSUE: the block SHALL drive o_mem_addr, o_mem_sel and o_mem_wdata, assert o_mem_re or o_mem_we for exactly one cycle, and move to RESP.
REQ-021 RESP: the block SHALL pulse o_ack[winner], drive o_rdata with i_mem_rdata for reads (00 for writes), and return to IDLE.
REQ-022 Latency: a request first sampled in IDLE at edge t SHALL produce its strobe in cycle t+1 and its ack in cycle t+2; peak throughput is one access per 3 cycles.
REQ-023 Default arbitration is round-robin: the search starts at a pointer, and the pointer SHALL be set to winner+1 (wrapping NUM_CORES-1 to 0) at each grant.
REQ-024 Both read and write codes nonzero from one core: the access SHALL be treated as a write, and o_err SHALL be set.
REQ-025 A request withdrawn before being granted SHALL be dropped silently; once latched, an access SHALL complete even if the request drops.
REQ-026 A requester holding its request past its ack cycle SHALL be re-arbitrated as a new request.
REQ-027 When idle, o_mem_re and o_mem_we SHALL be 0, o_ack SHALL be 0, and o_mem_addr, o_mem_sel and o_mem_wdata SHALL hold their last values.

Reset
REQ-028 On i_rst at a clock edge the block SHALL:
- go to IDLE, with pointer = 0;
- clear o_ack, o_mem_re, o_mem_we, o_busy and o_err;
- clear o_rdata, o_mem_addr, o_mem_sel and o_mem_wdata to 0.
REQ-029 Reset during ISSUE or RESP SHALL abandon the access, with no ack issued; a strobe already sampled by the DRAM is not undone.

Configuration
REQ-030 Macro DRAM_ARBITER_FIXED_PRIO_EN defined: arbitration SHALL be fixed priority, lowest core index wins, and the pointer logic is removed; undefined: round-robin per REQ-023.

Verification
REQ-031 NUM_CORES=4, core 2 reads addr 0x0105 code 01 with DRAM returning 0x3C -> o_mem_re in cycle t+1 with o_mem_addr=0x0105 and o_mem_sel=01; o_ack=0100 and o_rdata=0x3C in cycle t+2.
REQ-032 Core 0 writes 0xA5 to 0x2000 code 10 -> o_mem_we for one cycle with wdata 0xA5; o_ack=0001 two cycles after request sample; o_mem_re stays 0.
REQ-033 All four cores request continuously from reset -> grant order 0,1,2,3,0 with acks spaced 3 cycles apart; with DRAM_ARBITER_FIXED_PRIO_EN, core 0 is served every time.
REQ-034 Core 1 asserts read=01 and write=11 together -> write to region 11 is performed, o_err=1 and stays 1 until i_rst.
REQ-035 i_rst asserted in the ISSUE cycle -> next cycle o_busy=0 and o_ack=0000, and no ack is ever issued for that request.
